// File: rtl/addsub_chk_pkg.sv
// rtl/addsub_chk_pkg.sv - shared types and golden model for the adder_subtractor sweep checker
//
// Purpose: FSM state encoding and the reference add/subtract function used by
//          the checker to judge each DUT response.
// Contents:
//   MAX_N         widest operand the golden function supports
//   chk_state_e   sweep FSM states
//   addsub_golden returns {cout, ovf, s} for an n-bit operation; s is
//                 zero-extended to MAX_N bits so callers compare whole words
package addsub_chk_pkg;

  localparam int MAX_N = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } chk_state_e;

  // Subtract is a + ~b + 1, so cout is the "no borrow" flag (a >= b).
  // Overflow is judged on the effective second operand (b or ~b), which
  // covers both the add and the subtract sign rules with one expression.
  function automatic logic [MAX_N+1:0] addsub_golden(input int unsigned n,
                                                     input logic [MAX_N-1:0] a,
                                                     input logic [MAX_N-1:0] b,
                                                     input logic cin);
    logic [MAX_N-1:0] mask;
    logic [MAX_N-1:0] am;
    logic [MAX_N-1:0] bb;
    logic [MAX_N-1:0] s;
    logic [MAX_N:0]   sum;
    logic [4:0]       ci;
    logic [3:0]       si;
    logic             cout;
    logic             ovf;
    mask = {MAX_N{1'b1}} >> (MAX_N - n);
    am   = a & mask;
    bb   = cin ? (~b & mask) : (b & mask);
    sum  = {1'b0, am} + {1'b0, bb} + {{MAX_N{1'b0}}, cin};
    s    = sum[MAX_N-1:0] & mask;
    ci   = 5'(n);
    si   = 4'(n - 1);
    cout = sum[ci];
    ovf  = (am[si] == bb[si]) && (s[si] != am[si]);
    return {cout, ovf, s};
  endfunction

endpackage

// File: rtl/addsub_sweep_checker_if.sv
// rtl/addsub_sweep_checker_if.sv - vector/response bus between checker and adder_subtractor
//
// Purpose: bundles the operands driven to the adder_subtractor and its response.
// Modports:
//   master  checker side: drives a_o/b_o/cin_o, receives s_i/cout_i/ovf_i
//   slave   adder_subtractor side
interface addsub_sweep_checker_if #(
  parameter int N = 4
);
  logic [N-1:0] a_o;
  logic [N-1:0] b_o;
  logic         cin_o;
  logic [N-1:0] s_i;
  logic         cout_i;
  logic         ovf_i;

  modport master (output a_o, b_o, cin_o, input s_i, cout_i, ovf_i);
  modport slave  (input a_o, b_o, cin_o, output s_i, cout_i, ovf_i);
endinterface

// File: rtl/addsub_vec_gen.sv
// rtl/addsub_vec_gen.sv - (2N+1)-bit sweep vector counter
//
// Purpose: enumerates every {cin, a, b} combination, b fastest, cin slowest.
// Ports:
//   clk, rst  clock, async active-high reset
//   clr       restart at vector 0
//   inc       advance to the next vector
//   a, b, cin current vector fields
//   last      current vector is the final one (all ones)
module addsub_vec_gen #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         cin,
  output logic         last
);

  logic [2*N:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + (2*N+1)'(1);
    end
  end

  // A plain binary count gives the b -> a -> cin carry ripple for free.
  assign b    = cnt[N-1:0];
  assign a    = cnt[2*N-1:N];
  assign cin  = cnt[2*N];
  assign last = &cnt;

endmodule

// File: rtl/addsub_sweep_checker.sv
// rtl/addsub_sweep_checker.sv - exhaustive self-checking sweep of an adder_subtractor
//
// Purpose: on start, applies all 2^(2N+1) vectors, waits SETTLE cycles per
//          vector, compares the response with the golden model, counts
//          mismatches and latches the first failing vector.
// Ports:
//   clk, rst             clock, async active-high reset
//   start                begin a sweep (ignored while busy)
//   bus                  operands out / response in (master modport)
//   busy, done, pass     sweep status; done is a level held until next start
//   err_count            mismatching vectors (2N+2 bits, never wraps)
//   fail_valid           first failure latched
//   fail_a/b/cin         first failing vector
module addsub_sweep_checker
  import addsub_chk_pkg::*;
#(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  addsub_sweep_checker_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2*N+1:0]         err_count,
  output logic                   fail_valid,
  output logic [N-1:0]           fail_a,
  output logic [N-1:0]           fail_b,
  output logic                   fail_cin
);

  localparam logic [2:0] IDLE     = ST_IDLE;
  localparam logic [2:0] APPLY    = ST_APPLY;
  localparam logic [2:0] SETTLE_S = ST_SETTLE;
  localparam logic [2:0] CHECK    = ST_CHECK;
  localparam logic [2:0] DONE     = ST_DONE;
  localparam int         SW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [2:0]       state;
  logic [SW-1:0]    settle_cnt;
  logic [N-1:0]     vg_a;
  logic [N-1:0]     vg_b;
  logic             vg_cin;
  logic             vg_last;
  logic             accept;
  logic [MAX_N+1:0] gold;
  logic             mismatch;

  assign accept = start && (state == IDLE || state == DONE);

  addsub_vec_gen #(.N(N)) u_vec_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (state == CHECK && !vg_last),
    .a    (vg_a),
    .b    (vg_b),
    .cin  (vg_cin),
    .last (vg_last)
  );

  // Golden result for the vector currently held on the bus; the response is
  // packed the same way so one word compare covers s, cout and ovf.
  assign gold     = addsub_golden(N, MAX_N'(bus.a_o), MAX_N'(bus.b_o), bus.cin_o);
  assign mismatch = gold != {bus.cout_i, bus.ovf_i, MAX_N'(bus.s_i)};

  assign busy = (state == APPLY) || (state == SETTLE_S) || (state == CHECK);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      bus.a_o    <= '0;
      bus.b_o    <= '0;
      bus.cin_o  <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= APPLY;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
          end
        end
        APPLY: begin
          bus.a_o    <= vg_a;
          bus.b_o    <= vg_b;
          bus.cin_o  <= vg_cin;
          settle_cnt <= '0;
          state      <= SETTLE_S;
        end
        SETTLE_S: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + (2*N+2)'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= bus.a_o;
              fail_b     <= bus.b_o;
              fail_cin   <= bus.cin_o;
            end
          end
          if (vg_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sweep_checker.sv
// tb/tb_addsub_sweep_checker.sv - bench for addsub_sweep_checker with a faultable adder model
module tb_addsub_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, start0, rst1, start1;
  logic       busy0, done0, pass0, fv0, fcin0;
  logic [9:0] ec0;
  logic [3:0] fa0, fb0;
  logic       busy1, done1, pass1, fv1, fcin1;
  logic [9:0] ec1;
  logic [3:0] fa1, fb1;

  addsub_sweep_checker_if #(.N(4)) bus0 ();
  addsub_sweep_checker_if #(.N(4)) bus1 ();

  int   fmode = 0;
  int   fk    = 0;
  logic fval  = 1'b0;
  int   errors = 0;
  int   checks = 0;

  addsub_sweep_checker #(.N(4), .SETTLE(1)) dut0 (
    .clk(clk), .rst(rst0), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
    .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_cin(fcin0)
  );

  addsub_sweep_checker #(.N(4), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_cin(fcin1)
  );

  // Adder_subtractor behaviour from integer arithmetic, with optional faults:
  // 1 s[0] stuck 0, 2 ovf stuck 0, 3 cout inverted, 4 s[k] stuck at v.
  function automatic logic [5:0] adder_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin, input int mode,
                                             input int k, input logic v);
    int ai, bi, sa, sb, r, sr;
    logic [3:0] s;
    logic co, ov;
    ai = int'(a);
    bi = int'(b);
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    if (!cin) begin
      r  = ai + bi;
      co = (r >= 16);
      sr = sa + sb;
    end else begin
      r  = ai - bi;
      co = (ai >= bi);
      sr = sa - sb;
    end
    s  = 4'((r + 16) % 16);
    ov = (sr > 7) || (sr < -8);
    case (mode)
      1: s[0] = 1'b0;
      2: ov = 1'b0;
      3: co = ~co;
      4: s[k[1:0]] = v;
      default: ;
    endcase
    return {co, ov, s};
  endfunction

  always_comb {bus0.cout_i, bus0.ovf_i, bus0.s_i} =
    adder_model(bus0.a_o, bus0.b_o, bus0.cin_o, fmode, fk, fval);
  always_comb {bus1.cout_i, bus1.ovf_i, bus1.s_i} =
    adder_model(bus1.a_o, bus1.b_o, bus1.cin_o, 0, 0, 1'b0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outcome of a full sweep: walk the vectors in sweep order and
  // compare the faulty model against the fault-free one.
  task automatic ref_sweep(input int mode, input int k, input logic v,
                           output int cnt, output int ea, output int eb, output int ec);
    cnt = 0; ea = 0; eb = 0; ec = 0;
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          if (adder_model(4'(a), 4'(b), c[0], mode, k, v) !==
              adder_model(4'(a), 4'(b), c[0], 0, 0, 1'b0)) begin
            if (cnt == 0) begin ea = a; eb = b; ec = c; end
            cnt++;
          end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy0), 0);
    chk({tag, "_done"}, 32'(done0), 0);
    chk({tag, "_pass"}, 32'(pass0), 0);
    chk({tag, "_errcnt"}, 32'(ec0), 0);
    chk({tag, "_failvalid"}, 32'(fv0), 0);
    chk({tag, "_a_o"}, 32'(bus0.a_o), 0);
    chk({tag, "_b_o"}, 32'(bus0.b_o), 0);
    chk({tag, "_cin_o"}, 32'(bus0.cin_o), 0);
  endtask

  task automatic run0(input string tag, input int mode, input int k, input logic v,
                      input bit repulse, input int exp_cnt,
                      input int ea, input int eb, input int ec);
    int n;
    fmode = mode; fk = k; fval = v;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy0), 1);
    chk({tag, "_done_clr"}, 32'(done0), 0);
    n = 0;
    while (!done0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (repulse) start0 = (n == 100);
    end
    start0 = 1'b0;
    chk({tag, "_cycles"}, 32'(n), 1536);
    chk({tag, "_busy_fall"}, 32'(busy0), 0);
    chk({tag, "_errcnt"}, 32'(ec0), 32'(exp_cnt));
    chk({tag, "_pass"}, 32'(pass0), 32'(exp_cnt == 0));
    chk({tag, "_failvalid"}, 32'(fv0), 32'(exp_cnt != 0));
    if (exp_cnt != 0) begin
      chk({tag, "_fail_a"}, 32'(fa0), 32'(ea));
      chk({tag, "_fail_b"}, 32'(fb0), 32'(eb));
      chk({tag, "_fail_cin"}, 32'(fcin0), 32'(ec));
    end
  endtask

  initial begin
    int   cnt, ea, eb, ec, n, rk;
    logic rv;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    run0("good",     0, 0, 1'b0, 1'b0,   0, 0, 0, 0);
    run0("s0_stuck", 1, 0, 1'b0, 1'b0, 256, 0, 1, 0);
    run0("ovf_zero", 2, 0, 1'b0, 1'b0, 128, 1, 7, 0);
    run0("cout_inv", 3, 0, 1'b0, 1'b0, 512, 0, 0, 0);

    rk = int'($urandom_range(0, 3));
    rv = 1'($urandom_range(0, 1));
    ref_sweep(4, rk, rv, cnt, ea, eb, ec);
    run0("rand_stuck", 4, rk, rv, 1'b0, cnt, ea, eb, ec);

    run0("restart_ignored", 0, 0, 1'b0, 1'b1, 0, 0, 0, 0);

    // Faulty sweep aborted by reset part way through.
    fmode = 3;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n = 0;
    while (n < 699) begin @(negedge clk); n++; end
    chk("midrst_running", 32'(busy0), 1);
    rst0 = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    rst0 = 1'b0;
    @(negedge clk);
    run0("after_rst", 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

    // Longer settle time.
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    chk("settle3_busy", 32'(busy1), 1);
    n = 0;
    while (!done1 && n < 6000) begin @(negedge clk); n++; end
    chk("settle3_cycles", 32'(n), 2560);
    chk("settle3_pass", 32'(pass1), 1);
    chk("settle3_errcnt", 32'(ec1), 0);
    chk("settle3_failvalid", 32'(fv1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_sweep_checker.md
# addsub_sweep_checker

Self-checking sweep engine for the N-bit adder_subtractor. On `start` it drives every `(cin, a, b)` combination into the external adder_subtractor and samples `s`, `cout` and `ovf` after a programmable settle time. Each sample is compared against an internal golden model; the engine counts mismatches and latches the first failing vector. It sits beside the adder_subtractor instance as its consumer-side checker, for on-FPGA bring-up and for regression.

## Interface
- `N`, 4: operand width.
- `SETTLE`, 1: cycles (≥1) between applying a vector and sampling the response.
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: begin a sweep; ignored while `busy`.
- `a_o` out N: operand a to the DUT.
- `b_o` out N: operand b to the DUT.
- `cin_o` out 1: mode to the DUT; 0 = add, 1 = subtract.
- `s_i` in N: DUT sum/difference.
- `cout_i` in 1: DUT carry out.
- `ovf_i` in 1: DUT signed overflow.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep finished; level, held until the next accepted `start`.
- `pass` out 1: `done` and `err_count == 0`.
- `err_count` out 2N+2: number of mismatching vectors.
- `fail_valid` out 1: a first failure has been latched.
- `fail_a`, `fail_b` out N, `fail_cin` out 1: first failing vector.

## Operation
- Golden model for `cin=0`: `{cout, s} = a + b`.
- Golden model for `cin=1`: `{cout, s} = a + ~b + 1`, so `cout=1` iff `a >= b` unsigned.
- `ovf` = signed overflow of the two's-complement result. Add: operand sign bits equal and differ from `s[N-1]`. Subtract: `a`, `b` sign bits differ and `s[N-1]` differs from `a[N-1]`.
- A vector mismatches if any of `s`, `cout`, `ovf` differs; one mismatch increments `err_count` by 1.
- Sweep order: `cin` outermost (0 then 1), then `a`, then `b` innermost, each ascending from 0. Total 2^(2N+1) vectors (512 for N=4).
- FSM states:
  - IDLE: `start` → APPLY; clear `err_count`, `fail_*`, `done`, and set the vector counter to 0.
  - APPLY: register the vector onto `a_o`/`b_o`/`cin_o`; → SETTLE.
  - SETTLE: count `SETTLE` cycles, then → CHECK.
  - CHECK: compare and update counters. Last vector → DONE; otherwise increment the vector counter (carry ripples b→a→cin) and → APPLY.
  - DONE: `start` → APPLY, behaving as from IDLE.
- `fail_*` load only on the first mismatch (`fail_valid` 0→1); later mismatches leave them unchanged.
- `err_count` is 2N+2 bits wide, so it holds the all-fail value 2^(2N+1) without wrap. No saturation logic.

## Timing
- Reset values: all outputs 0, state IDLE, `a_o`/`b_o`/`cin_o` = 0.
- `start` is sampled on a rising edge in IDLE/DONE. `busy` rises on the next edge.
- Each vector takes 2+SETTLE cycles: 1 APPLY, SETTLE in SETTLE, 1 CHECK.
- DUT inputs are stable from the end of APPLY through CHECK. `s_i`, `cout_i`, `ovf_i` are sampled in CHECK only.
- `done` rises, and `busy` falls, on the edge that leaves the final CHECK: (2+SETTLE)·2^(2N+1) cycles after `busy` rises (1536 for defaults).
- `start` while `busy` has no effect.
- `rst` mid-sweep returns immediately to the reset values; there is no resume.

## Structure
- Package `addsub_chk_pkg`:
  - state enum (IDLE, APPLY, SETTLE, CHECK, DONE);
  - golden function `addsub_golden(a, b, cin)` returning `{cout, ovf, s}`, parameterised by N.
- Sub-module `addsub_vec_gen`: (2N+1)-bit vector counter with `clr`/`inc`/`last` and split `a`/`b`/`cin` outputs.

## Test plan
- Correct adder_subtractor attached, defaults: `start` pulse → `done=1`, `pass=1`, `err_count=0`, `fail_valid=0`, 1536 cycles after `busy` rises.
- `s_i[0]` forced to 0: `err_count=256`; first fail `cin=0`, `a=0`, `b=1`.
- `ovf_i` forced to 0: `err_count=128` (64 add + 64 subtract); first fail `cin=0`, `a=1`, `b=7`.
- `cout_i` inverted: `err_count=512`, `pass=0`; first fail `cin=0`, `a=0`, `b=0`.
- `start` re-pulsed at cycle 100 of a sweep: ignored, and `done` still arrives at cycle 1536. `rst` at cycle 700: all outputs 0 next edge. A new `start` then runs a full 1536-cycle sweep.
- `SETTLE=3`: sweep takes 5·512 = 2560 cycles. Correct DUT → `pass=1`.
